// File: rtl/rst_step_gen_pkg.sv
// rst_step_pkg: shared reset-FSM state encoding and default parameter values for rst_step_gen.
// Macro STEP_AUTOREPEAT_EN adds the step auto-repeat timing defaults.
package rst_step_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, EXTEND = 2'd2} rst_state_t;
    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [7:0]  DEF_RST_HOLD        = 8'd16;
    localparam int          DEF_CNT_W           = 16;
`ifdef STEP_AUTOREPEAT_EN
    localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
    localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd1000000;
`endif
endpackage

// File: rtl/rst_step_gen_if.sv
// rst_step_gen_if: button inputs and conditioned outputs of rst_step_gen.
// BTN_RST/BTN_STEP raw buttons; SYS_RST stretched reset; STEP_PULSE one-cycle strobe; BTN_STEP_DB debounced step level.
interface rst_step_gen_if;
    logic BTN_RST;
    logic BTN_STEP;
    logic SYS_RST;
    logic STEP_PULSE;
    logic BTN_STEP_DB;
    modport master (output BTN_RST, BTN_STEP, input SYS_RST, STEP_PULSE, BTN_STEP_DB);
    modport slave  (input BTN_RST, BTN_STEP, output SYS_RST, STEP_PULSE, BTN_STEP_DB);
endinterface

// File: rtl/rst_step_gen_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-count debouncer for one raw button.
// Ports: B_CLK clock, RST sync active-high reset, btn raw input, db debounced level.
module btn_debounce
    import rst_step_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          CNT_W           = DEF_CNT_W
)(
    input  logic B_CLK,
    input  logic RST,
    input  logic btn,
    output logic db
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge B_CLK) begin
        if (RST) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == db) cnt <= '0;
            else if (cnt == LAST) begin
                db  <= s2;
                cnt <= '0;
            end else cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/rst_step_gen.sv
// rst_step_gen: debounces reset/step buttons, produces a stretched SYS_RST and a one-cycle STEP_PULSE.
// Ports: B_CLK board clock, RST sync active-high reset, bus (slave) carrying buttons and conditioned outputs.
// Optional macro STEP_AUTOREPEAT_EN: repeats STEP_PULSE while the step button is held.
module rst_step_gen
    import rst_step_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [7:0]  RST_HOLD        = DEF_RST_HOLD,
    parameter int          CNT_W           = DEF_CNT_W
`ifdef STEP_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
)(
    input logic B_CLK,
    input logic RST,
    rst_step_gen_if.slave bus
);
    logic db_rst, db_step, rst_prev, step_prev;
    logic sys_rst_q, step_pulse_q, step_ok, step_fire;
    logic [7:0] hold_cnt;
    rst_state_t state, nxt;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_rst (
        .B_CLK(B_CLK), .RST(RST), .btn(bus.BTN_RST), .db(db_rst));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
        .B_CLK(B_CLK), .RST(RST), .btn(bus.BTN_STEP), .db(db_step));
    always_comb begin
        nxt = HOLD;
        case (state)
            RUN:     nxt = (db_rst & ~rst_prev) ? HOLD : RUN;
            HOLD:    nxt = (hold_cnt == RST_HOLD - 8'd1) ? (db_rst ? EXTEND : RUN) : HOLD;
            EXTEND:  nxt = db_rst ? EXTEND : RUN;
            default: nxt = HOLD;
        endcase
    end
    // A step edge only counts when reset is neither active nor being entered on this edge.
    assign step_ok = db_step & ~step_prev & (state == RUN) & (nxt == RUN);
    always_ff @(posedge B_CLK) begin
        if (RST) begin
            state        <= HOLD;
            hold_cnt     <= 8'd0;
            sys_rst_q    <= 1'b1;
            step_pulse_q <= 1'b0;
            rst_prev     <= 1'b0;
            step_prev    <= 1'b0;
        end else begin
            state        <= nxt;
            hold_cnt     <= (state == HOLD && nxt == HOLD) ? hold_cnt + 8'd1 : 8'd0;
            sys_rst_q    <= (nxt != RUN);
            step_pulse_q <= step_fire;
            rst_prev     <= db_rst;
            step_prev    <= db_step;
        end
    end
`ifdef STEP_AUTOREPEAT_EN
    // rpt_cnt counts cycles since the last pulse while held; 0 means idle.
    logic [23:0] rpt_cnt;
    logic rpt_first, running, rpt_fire;
    assign running   = (state == RUN) & (nxt == RUN);
    assign rpt_fire  = running & db_step & (rpt_cnt != 24'd0) &
                       (rpt_cnt == (rpt_first ? REPEAT_DELAY : REPEAT_PERIOD));
    assign step_fire = step_ok | rpt_fire;
    always_ff @(posedge B_CLK) begin
        if (RST || !db_step || !running) begin
            rpt_cnt   <= 24'd0;
            rpt_first <= 1'b0;
        end else if (step_ok || rpt_fire) begin
            rpt_cnt   <= 24'd1;
            rpt_first <= step_ok;
        end else if (rpt_cnt != 24'd0) rpt_cnt <= rpt_cnt + 24'd1;
    end
`else
    assign step_fire = step_ok;
`endif
    assign bus.SYS_RST     = sys_rst_q;
    assign bus.STEP_PULSE  = step_pulse_q;
    assign bus.BTN_STEP_DB = db_step;
endmodule
